// File: rtl/adc_scan_scheduler.sv
// ADC128S102 periodic scan scheduler: walks enabled channels on each period tick and
// re-tags results for the ADC's one-frame address pipeline. Optional timeout: define SCAN_TIMEOUT_EN.
module adc_scan_scheduler #(
  parameter int PERIOD_W    = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Stop,
  input  logic [7:0]          Ch_Mask,
  input  logic [PERIOD_W-1:0] Period,
  output logic                Adc_En_Conv,
  output logic [2:0]          Adc_Channel,
  input  logic [11:0]         Adc_Data,
  input  logic                Adc_Conv_Done,
  output logic                Sample_Valid,
  input  logic                Sample_Ready,
  output logic [15:0]         Sample_Data,
  output logic                Busy,
  output logic                Scan_Done,
  output logic                Scan_Overrun,
  output logic                Err_Timeout,
  input  logic                Clr_Err
);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE, PUSH} state_t;
  state_t state, state_nxt;

  logic [PERIOD_W-1:0] timer;
  logic [7:0]          scan_mask;
  logic [2:0]          first_ch, last_ch, next_ch, new_first, chan, tag_ch;
  logic [15:0]         smp;
  logic                tick, accept, end_scan, timeout, stop_req;
  logic                prime, last_smp, stop_pend, busy_q, done_q, ovr_q, tmo_q;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // >= rather than == so a Period lowered below the running count still wraps promptly
  assign tick     = (state != IDLE) && (timer >= Period);
  assign accept   = (state == PUSH) && Sample_Ready;
  assign end_scan = (accept && last_smp) || timeout;
  assign stop_req = Stop || (stop_pend && !Start);

  always_comb begin
    new_first = 3'd0;
    for (int i = 7; i >= 0; i--) if (Ch_Mask[i]) new_first = 3'(i);
  end

  always_comb begin
    last_ch = 3'd0;
    for (int i = 0; i < 8; i++) if (scan_mask[i]) last_ch = 3'(i);
  end

  // Following set bit after the current address; wraps to the first channel for the flush frame
  always_comb begin
    next_ch = first_ch;
    for (int i = 7; i >= 0; i--) if (scan_mask[i] && (i > int'(chan))) next_ch = 3'(i);
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;

  always_ff @(posedge Clk) begin
    if (Rst || state != WAIT_DONE || Adc_Conv_Done) wd_cnt <= '0;
    else                                            wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_DONE) && !Adc_Conv_Done && (wd_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (Start && (Ch_Mask != 8'd0)) state_nxt = WAIT_TICK;
      WAIT_TICK: if (stop_req)                   state_nxt = IDLE;
                 else if (tick)                  state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (Adc_Conv_Done)              state_nxt = prime ? ISSUE : PUSH;
                 else if (timeout)               state_nxt = stop_req ? IDLE : WAIT_TICK;
      PUSH:      if (Sample_Ready)               state_nxt = !last_smp ? ISSUE :
                                                             (stop_req ? IDLE : WAIT_TICK);
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Adc_En_Conv  = 1'b0;
    Sample_Valid = 1'b0;
    case (state)
      ISSUE:   Adc_En_Conv  = 1'b1;
      PUSH:    Sample_Valid = 1'b1;
      default: ;
    endcase
  end

  assign Adc_Channel  = chan;
  assign Sample_Data  = smp;
  assign Busy         = busy_q;
  assign Scan_Done    = done_q;
  assign Scan_Overrun = ovr_q;
  assign Err_Timeout  = tmo_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      timer     <= '0;
      scan_mask <= '0;
      first_ch  <= '0;
      chan      <= '0;
      tag_ch    <= '0;
      smp       <= '0;
      prime     <= 1'b0;
      last_smp  <= 1'b0;
      stop_pend <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      timer  <= (state == IDLE || tick) ? '0 : timer + 1'b1;
      done_q <= accept && last_smp;

      if (tick && busy_q) ovr_q <= 1'b1;
      else if (Clr_Err)   ovr_q <= 1'b0;
      if (timeout)        tmo_q <= 1'b1;
      else if (Clr_Err)   tmo_q <= 1'b0;

      if (state_nxt == IDLE) stop_pend <= 1'b0;
      else if (Stop)         stop_pend <= 1'b1;
      else if (Start)        stop_pend <= 1'b0;

      if (state == WAIT_TICK && state_nxt == ISSUE) begin
        scan_mask <= Ch_Mask;
        first_ch  <= new_first;
        chan      <= new_first;
        prime     <= 1'b1;
        busy_q    <= 1'b1;
      end

      // The frame just finished converted the channel addressed one frame earlier (tag_ch)
      if (state == WAIT_DONE && Adc_Conv_Done) begin
        if (prime) begin
          prime  <= 1'b0;
          tag_ch <= chan;
          chan   <= next_ch;
        end else begin
          smp      <= {1'b0, tag_ch, Adc_Data};
          last_smp <= (tag_ch == last_ch);
        end
      end

      if (accept && !last_smp) begin
        tag_ch <= chan;
        chan   <= next_ch;
      end

      if (end_scan) busy_q <= 1'b0;
    end
  end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
- Periodic multi-channel scan controller for the ADC128S102 serial ADC interface block.
- On each sample-period tick it walks the enabled channels of an 8-bit mask and issues one-shot conversions (En_Conv/Channel).
- It re-tags the results to compensate for the ADC's one-frame address pipeline: the address sent in frame N selects the channel converted in frame N+1.
- It delivers channel-tagged samples on a valid/ready stream toward the DDR acquisition path.

Parameters:
- PERIOD_W, 24, width of sample-period register.
- TIMEOUT_CYC, 4096, Clk cycles allowed between En_Conv and Conv_Done (optional feature only).

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- Start  in  1  pulse: begin periodic scanning
- Stop  in  1  pulse: finish current scan, then go idle
- Ch_Mask  in  8  enabled channels, bit i = channel i
- Period  in  PERIOD_W  scan period = Period+1 Clk cycles
- Adc_En_Conv  out  1  one-cycle conversion request to ADC block
- Adc_Channel  out  3  channel address to ADC block
- Adc_Data  in  12  ADC result
- Adc_Conv_Done  in  1  one-cycle done strobe, Adc_Data valid same cycle
- Sample_Valid  out  1  output sample valid
- Sample_Ready  in  1  downstream accept
- Sample_Data  out  16  {1'b0, ch[2:0], data[11:0]}
- Busy  out  1  scan in progress
- Scan_Done  out  1  one-cycle pulse after the last sample of a scan is accepted
- Scan_Overrun  out  1  sticky: tick arrived while a scan was busy
- Err_Timeout  out  1  sticky timeout error (optional feature)
- Clr_Err  in  1  clears sticky flags

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0. Rst mid-scan aborts immediately with no partial sample emitted. The ADC block's Rst_n is driven from ~Rst at the top level.
- States:
  - IDLE
  - WAIT_TICK
  - ISSUE
  - WAIT_DONE
  - PUSH
- IDLE: Start with Ch_Mask != 0 -> WAIT_TICK, timer cleared. Start with Ch_Mask == 0 is ignored.
- Timer: runs whenever not IDLE. It counts 0..Period; the tick fires at count == Period, then wraps to 0. Period = 0 gives a tick every cycle.
- Tick in WAIT_TICK:
  - Latch Ch_Mask into scan_mask and set Busy = 1.
  - Select the lowest set bit as first channel.
  - Set prime = 1 and go to ISSUE.
- Tick while Busy: dropped; Scan_Overrun <= 1.
- ISSUE:
  - Adc_En_Conv = 1 for exactly one cycle; Adc_Channel = next channel (the following set bit in scan_mask).
  - After the last set bit, Adc_Channel = first channel (flush conversion).
  - Adc_Channel is held stable until Conv_Done; then go to WAIT_DONE.
- WAIT_DONE, on Adc_Conv_Done:
  - If prime: discard the result, clear prime, return to ISSUE.
  - Otherwise: load Sample_Data with tag = previously addressed channel and go to PUSH.
- PUSH:
  - Sample_Valid = 1; Sample_Data is held stable until Sample_Ready.
  - On accept: if the accepted sample was the last mask channel, pulse Scan_Done, clear Busy and go to WAIT_TICK (or IDLE if Stop is pending). Otherwise go to ISSUE.
- Conversions per scan: popcount(mask)+1. Samples per scan: popcount(mask), emitted in ascending channel order.
- Back-pressure: a stalled Sample_Ready stalls the scan; no samples are ever dropped.
- Stop: latched as pending. If not Busy, go to IDLE next cycle; otherwise go to IDLE after Scan_Done. Start while pending clears the pending Stop.
- Ch_Mask and Period changes mid-scan take effect at the next scan start. Period is sampled continuously by the timer.
- Simultaneous Clr_Err and a new overrun: the set wins.
- Single-channel mask: 2 conversions; both address that channel.

Optional Feature:
- Macro SCAN_TIMEOUT_EN.
- Defined: a WAIT_DONE cycle counter runs. When it reaches TIMEOUT_CYC without Conv_Done, the scheduler:
  - sets Err_Timeout;
  - abandons the scan without emitting further samples;
  - clears Busy;
  - goes to WAIT_TICK, or IDLE if Stop is pending.
- Not defined: no counter; WAIT_DONE waits indefinitely; Err_Timeout tied 0.

Test Plan:
- Ch_Mask=8'h05, Period=999, Start; ADC model returns 12'h100+addressed_ch of the previous frame -> Adc_Channel sequence 0,2,0. Samples 16'h0100 and 16'h2102, then Scan_Done. Next scan begins 1000 cycles after the previous tick.
- Ch_Mask=8'h80 -> 2 conversions, both Adc_Channel=7, one sample 16'h7xxx per tick.
- Sample_Ready held low 5000 cycles with Period=99 -> Sample_Data stable, no Adc_En_Conv during the stall, Scan_Overrun=1. Clr_Err clears it.
- Stop mid-scan with mask 8'hFF -> all 8 samples emitted, Scan_Done, then IDLE with no further En_Conv. Start with Ch_Mask=0 -> stays IDLE.
- Rst asserted in WAIT_DONE -> all outputs 0 next cycle; later Start yields a correct full scan with prime discard.
- (SCAN_TIMEOUT_EN, TIMEOUT_CYC=4096) ADC model never returns done -> Err_Timeout set at 4096 cycles, Busy=0, next tick restarts the scan.
